// File: rtl/add_pkg.sv
// Shared types and the operand-recovery function for the adder inverse checker.
package add_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned SUM_W  = 5;
    localparam int unsigned DIFF_W = 6;
    localparam int unsigned OP_MAX = (1 << OP_W) - 1;

    // Observed adder transaction: result plus the known operand.
    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic [OP_W-1:0]  a;
    } add_req_t;

    // Recovered operand and consistency flag.
    typedef struct packed {
        logic [OP_W-1:0] b;
        logic            err;
    } add_rsp_t;

    // b = (sum - a) mod 16; err when no 4-bit b can produce sum from a.
    function automatic add_rsp_t add_recover(input logic [SUM_W-1:0] sum,
                                             input logic [OP_W-1:0]  a);
        logic [DIFF_W-1:0] diff;
        add_rsp_t          rsp;
        diff    = DIFF_W'({1'b0, sum}) - DIFF_W'({2'b00, a});
        rsp.b   = diff[OP_W-1:0];
        rsp.err = (sum < SUM_W'(a)) || (diff[SUM_W-1:0] > SUM_W'(OP_MAX));
        return rsp;
    endfunction

endpackage

// File: rtl/add_inverse_stage.sv
// One valid/ready register slice; ready looks only at local state and downstream ready.
module add_inverse_stage #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    output logic o_ready,
    input  T     i_data,
    output logic o_valid,
    input  logic i_ready,
    output T     o_data
);

    logic r_valid;
    T     r_data;

    // Accept when empty or when the held item leaves this cycle.
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Load on input transfer, drain when downstream takes the item with nothing new.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_valid && o_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/add_inverse.sv
// Two-stage pipelined inverse of the 4-bit adder with transaction/error counters.
module add_inverse
    import add_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SUM_W-1:0]   in_sum,
    input  logic [OP_W-1:0]    in_a,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    out_b,
    output logic               out_err,
    output logic [CNT_W-1:0]   txn_cnt,
    output logic [CNT_W-1:0]   err_cnt
);

    add_req_t         w_in_req;
    add_req_t         w_s1_req;
    add_rsp_t         w_s1_rsp;
    add_rsp_t         w_s2_rsp;
    logic             w_s1_valid;
    logic             w_s2_free;
    logic             w_out_fire;
    logic [CNT_W-1:0] r_txn_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    assign w_in_req.sum = in_sum;
    assign w_in_req.a   = in_a;

    // S1: captured request.
    add_inverse_stage #(.T(add_req_t)) u_s1 (
        .clk     (clk),
        .rst     (rst),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_in_req),
        .o_valid (w_s1_valid),
        .i_ready (w_s2_free),
        .o_data  (w_s1_req)
    );

    // Recovery arithmetic between the stages.
    assign w_s1_rsp = add_recover(w_s1_req.sum, w_s1_req.a);

    // S2: registered result presented downstream.
    add_inverse_stage #(.T(add_rsp_t)) u_s2 (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_s1_valid),
        .o_ready (w_s2_free),
        .i_data  (w_s1_rsp),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_s2_rsp)
    );

    assign out_b      = w_s2_rsp.b;
    assign out_err    = w_s2_rsp.err;
    assign w_out_fire = out_valid && out_ready;

    // Delivered-result counters: txn wraps, err saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txn_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_out_fire) begin
            r_txn_cnt <= r_txn_cnt + CNT_W'(1);
            if (out_err && (r_err_cnt != {CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign txn_cnt = r_txn_cnt;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_add_inverse.sv
// Directed bench for add_inverse: latency, errors, streaming, backpressure, reset, counter limits.
module tb_add_inverse;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_sum;
    logic [3:0] in_a;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_b;
    logic       out_err;
    logic [7:0] txn_cnt;
    logic [7:0] err_cnt;

    logic       s_rst;
    logic       s_in_valid;
    logic       s_in_ready;
    logic [4:0] s_in_sum;
    logic [3:0] s_in_a;
    logic       s_out_valid;
    logic       s_out_ready;
    logic [3:0] s_out_b;
    logic       s_out_err;
    logic [1:0] s_txn_cnt;
    logic [1:0] s_err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    add_inverse #(.CNT_W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_b     (out_b),
        .out_err   (out_err),
        .txn_cnt   (txn_cnt),
        .err_cnt   (err_cnt)
    );

    add_inverse #(.CNT_W(2)) u_small (
        .clk       (clk),
        .rst       (s_rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_sum    (s_in_sum),
        .in_a      (s_in_a),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_b     (s_out_b),
        .out_err   (s_out_err),
        .txn_cnt   (s_txn_cnt),
        .err_cnt   (s_err_cnt)
    );

    task automatic test_reset;
        rst = 1'b1; s_rst = 1'b1;
        in_valid = 1'b0; in_sum = '0; in_a = '0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_sum = '0; s_in_a = '0; s_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; s_rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (out_b !== 4'h0) begin errors++; $display("FAIL reset_out_b got %0h exp 0", out_b); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %0b exp 0", out_err); end
        checks++; if (txn_cnt !== 8'd0) begin errors++; $display("FAIL reset_txn got %0d exp 0", txn_cnt); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        checks++; if (s_txn_cnt !== 2'd0 || s_err_cnt !== 2'd0) begin errors++; $display("FAIL reset_small_cnt got %0d/%0d exp 0/0", s_txn_cnt, s_err_cnt); end
    endtask

    task automatic test_basic;
        @(negedge clk);
        in_valid = 1'b1; in_sum = 5'd7; in_a = 4'd3; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0b exp 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", out_valid); end
        checks++; if (out_b !== 4'd4) begin errors++; $display("FAIL basic_b got %0h exp 4", out_b); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL basic_err got %0b exp 0", out_err); end
        @(negedge clk);
        checks++; if (txn_cnt !== 8'd1) begin errors++; $display("FAIL basic_txn got %0d exp 1", txn_cnt); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL basic_err_cnt got %0d exp 0", err_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %0b exp 0", out_valid); end
    endtask

    task automatic test_errors;
        @(negedge clk);
        in_valid = 1'b1; in_sum = 5'd2; in_a = 4'd5;
        @(negedge clk);
        in_sum = 5'd31; in_a = 4'd0;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_b !== 4'hD || out_err !== 1'b1) begin errors++; $display("FAIL err_underflow got v=%0b b=%0h e=%0b exp v=1 b=d e=1", out_valid, out_b, out_err); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_b !== 4'hF || out_err !== 1'b1) begin errors++; $display("FAIL err_overflow got v=%0b b=%0h e=%0b exp v=1 b=f e=1", out_valid, out_b, out_err); end
        @(negedge clk);
        checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL err_cnt got %0d exp 2", err_cnt); end
        checks++; if (txn_cnt !== 8'd3) begin errors++; $display("FAIL err_txn got %0d exp 3", txn_cnt); end
    endtask

    // 16 back-to-back pairs; counts are cumulative (3 delivered before this test).
    task automatic test_streaming;
        out_ready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            if (k < 16) begin
                in_valid = 1'b1; in_sum = 5'(2 * k); in_a = 4'(k);
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready k=%0d got %0b exp 1", k, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            if (k >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_b !== 4'(k - 2) || out_err !== 1'b0) begin
                    errors++; $display("FAIL stream_out k=%0d got v=%0b b=%0h e=%0b exp v=1 b=%0h e=0", k, out_valid, out_b, out_err, k - 2);
                end
            end
            @(negedge clk);
        end
        checks++; if (txn_cnt !== 8'd19) begin errors++; $display("FAIL stream_txn got %0d exp 19", txn_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %0b exp 0", out_valid); end
    endtask

    task automatic test_backpressure;
        logic [4:0] sums [4];
        logic [3:0] as   [4];
        logic [3:0] exp_b[4];
        int n_acc;
        int n_out;
        sums[0] = 5'd9;  as[0] = 4'd1; exp_b[0] = 4'd8;
        sums[1] = 5'd12; as[1] = 4'd2; exp_b[1] = 4'd10;
        sums[2] = 5'd5;  as[2] = 4'd5; exp_b[2] = 4'd0;
        sums[3] = 5'd15; as[3] = 4'd4; exp_b[3] = 4'd11;
        n_acc = 0; n_out = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_sum = sums[n_acc]; in_a = as[n_acc];
            #1;
            if (c >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_b !== exp_b[0]) begin
                    errors++; $display("FAIL bp_hold c=%0d got v=%0b b=%0h exp v=1 b=%0h", c, out_valid, out_b, exp_b[0]);
                end
            end
            if (in_ready) n_acc++;
            @(negedge clk);
        end
        checks++; if (n_acc !== 2) begin errors++; $display("FAIL bp_accepted got %0d exp 2", n_acc); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %0b exp 0", in_ready); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b exp 1", in_ready); end
        for (int c = 0; c < 12 && n_out < 4; c++) begin
            in_valid = (n_acc < 4);
            if (n_acc < 4) begin in_sum = sums[n_acc]; in_a = as[n_acc]; end
            #1;
            if (out_valid) begin
                checks++;
                if (out_b !== exp_b[n_out]) begin
                    errors++; $display("FAIL bp_order idx=%0d got %0h exp %0h", n_out, out_b, exp_b[n_out]);
                end
                n_out++;
            end
            if (in_valid && in_ready) n_acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (n_out !== 4) begin errors++; $display("FAIL bp_delivered got %0d exp 4", n_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_duplicate got %0b exp 0", out_valid); end
        checks++; if (txn_cnt !== 8'd23) begin errors++; $display("FAIL bp_txn got %0d exp 23", txn_cnt); end
    endtask

    task automatic test_reset_stall;
        out_ready = 1'b0;
        in_valid = 1'b1; in_sum = 5'd9; in_a = 4'd1;
        @(negedge clk);
        in_sum = 5'd12; in_a = 4'd2;
        @(negedge clk);
        in_sum = 5'd3; in_a = 4'd1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL rs_full got rdy=%0b v=%0b exp rdy=0 v=1", in_ready, out_valid); end
        rst = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rs_out_valid got %0b exp 0", out_valid); end
        checks++; if (txn_cnt !== 8'd0 || err_cnt !== 8'd0) begin errors++; $display("FAIL rs_counters got %0d/%0d exp 0/0", txn_cnt, err_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rs_in_ready got %0b exp 1", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rs_flushed got %0b exp 0", out_valid); end
        in_valid = 1'b1; in_sum = 5'd10; in_a = 4'd4;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_b !== 4'd6 || out_err !== 1'b0) begin errors++; $display("FAIL rs_after got v=%0b b=%0h e=%0b exp v=1 b=6 e=0", out_valid, out_b, out_err); end
        @(negedge clk);
        checks++; if (txn_cnt !== 8'd1) begin errors++; $display("FAIL rs_txn got %0d exp 1", txn_cnt); end
    endtask

    // CNT_W=2 instance: 5 deliveries wrap txn to 1, 4 errors saturate err at 3.
    task automatic test_counter_limits;
        logic [4:0] sums[5];
        logic [3:0] as  [5];
        sums[0] = 5'd2;  as[0] = 4'd5;
        sums[1] = 5'd31; as[1] = 4'd0;
        sums[2] = 5'd7;  as[2] = 4'd3;
        sums[3] = 5'd0;  as[3] = 4'd1;
        sums[4] = 5'd20; as[4] = 4'd2;
        s_out_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            s_in_valid = 1'b1; s_in_sum = sums[k]; s_in_a = as[k];
            checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL lim_in_ready k=%0d got %0b exp 1", k, s_in_ready); end
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (s_txn_cnt !== 2'd1) begin errors++; $display("FAIL lim_txn_wrap got %0d exp 1", s_txn_cnt); end
        checks++; if (s_err_cnt !== 2'd3) begin errors++; $display("FAIL lim_err_sat got %0d exp 3", s_err_cnt); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_errors;
        test_streaming;
        test_backpressure;
        test_reset_stall;
        test_counter_limits;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_inverse.md
# add_inverse

Pipelined inverse of the 4-bit adder: given an adder result `sum` (5 bits) and one operand `a` (4 bits), recovers the other operand `b = sum - a` and flags inconsistent pairs. It sits on the checking side of the adder interface, consuming observed adder transactions through a valid/ready handshake and emitting recovered operands with a consistency flag. It also keeps running transaction and error counts for the bench.

## Interface

**Parameters**
- `CNT_W`, default 8: width of the transaction and error counters.

**Ports**
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `sum`/`a` pair presented.
- `in_ready` output 1: block accepts the pair this cycle.
- `in_sum` input 5: adder result.
- `in_a` input 4: known operand.
- `out_valid` output 1: recovered result presented.
- `out_ready` input 1: downstream accepts the result this cycle.
- `out_b` output 4: recovered operand.
- `out_err` output 1: pair is not producible by a 4-bit + 4-bit add.
- `txn_cnt` output CNT_W: results delivered; wraps.
- `err_cnt` output CNT_W: delivered results with `out_err=1`; saturates.

## Operation

**Handshake**
- A transfer occurs on an edge where valid and ready are both 1.
- `in_valid` may depend on nothing from this block.
- `in_ready` is combinational from internal state and `out_ready` only, never from `in_valid`.

**Pipeline** (two register stages)
- S1 holds the captured `sum`, `a` and `s1_valid`.
- S2 holds `out_b`, `out_err` and `out_valid`.
- `s2_free = !out_valid || out_ready`
- `s1_adv = s1_valid && s2_free`
- `in_ready = !s1_valid || s2_free`
- On `s1_adv`: S2 loads the S1 result and `out_valid` goes to 1.
- When `out_valid && out_ready` and nothing advances, `out_valid` goes to 0.
- On an input transfer: S1 loads and `s1_valid` goes to 1. When S1 advances with no new input, `s1_valid` goes to 0.

**Arithmetic**
- `diff = {1'b0,sum} - {2'b0,a}`, 6 bits.
- `out_b = diff[3:0]`, i.e. modulo 16.
- `out_err = (sum < a) || (sum - a > 15)`.

**Counters** (update on output transfer only)
- `txn_cnt` increments and wraps.
- `err_cnt` increments when `out_err=1` and holds at all-ones.

**Stall**
- While `out_ready=0`, S2 holds `out_b` and `out_err` stable and `out_valid` stays 1.
- S1 fills if empty; once both stages are full, `in_ready` is 0.

**Reset**
- `rst` overrides everything, including a reset mid-stall or mid-transfer.
- In-flight data is discarded and no counter updates occur on that edge.

## Timing

**Reset values**
- `out_valid=0`, `out_b=0`, `out_err=0`, `txn_cnt=0`, `err_cnt=0`, `s1_valid=0`.
- `in_ready` is 1 in the cycle after reset.

**Latency and throughput**
- Input accepted at edge N gives `out_valid=1` after edge N+1 (visible in cycle N+1 to N+2), assuming no stall.
- Throughput is 1 transaction per cycle with `out_ready` held at 1.

**Simultaneous events**
- Input transfer, S1 advance and output transfer all in the same cycle are legal.
- Both stages stay full and the counters increment once.

**Backpressure recovery**
- When `out_ready` rises with both stages full, `in_ready` is 1 in the same cycle.
- No bubble and no data loss.

**Ordering**
- No reordering and no duplication: every accepted pair appears exactly once at the output, in order.

## Structure

**Package `add_pkg`**
- Localparams `OP_W=4` and `SUM_W=5`.
- Typedef `add_req_t` (`sum`, `a`).
- Typedef `add_rsp_t` (`b`, `err`).
- Pure function `add_recover(sum, a)` returning `add_rsp_t`, shared with the bench reference model.

**Sub-module `add_inverse_stage`**
- One valid/ready register slice, parameterized by payload type.
- Instantiated twice: S1 carries `add_req_t`, S2 carries `add_rsp_t` computed between the stages.

## Test plan

- **Basic:** reset, then send (sum=7, a=3), `out_ready=1` -> `out_b=4`, `out_err=0`, two cycles after acceptance; then `txn_cnt=1`, `err_cnt=0`.
- **Error cases:** send (sum=2, a=5) -> `out_b=0xD`, `out_err=1`; send (sum=31, a=0) -> `out_b=0xF`, `out_err=1`; then `err_cnt=2`.
- **Streaming:** 16 back-to-back pairs (sum=i+i, a=i) for i=0..15 with `out_ready=1` -> 16 consecutive results `out_b=i`, `out_err=0`, no idle cycle; then `txn_cnt=16`.
- **Backpressure:** `out_ready=0` for 5 cycles while `in_valid=1` -> exactly 2 pairs accepted, `in_ready=0` thereafter, `out_b` stable. Then release -> all pairs delivered in order, none lost or duplicated.
- **Reset mid-stall:** both stages full, assert `rst` for 1 cycle -> next cycle `out_valid=0`, counters 0, `in_ready=1`; the following pair (sum=10, a=4) yields `out_b=6`.
- **Counter limits:** with CNT_W=2, deliver 5 pairs of which 4 are errors -> `txn_cnt=1` (wrapped), `err_cnt=3` (saturated).
